// File: rtl/keypad_entry_buffer_if.sv
// Bus between the keystroke source / ATM FSM and keypad_entry_buffer.
//
// Handshake: arm and key_valid are single-cycle request pulses with no ready
// back-pressure; the buffer samples them on every rising clock edge. busy is
// high while an entry is being collected or converted, done is a one-cycle
// completion strobe, and bcd_out/value_out/status_code hold their values
// from done until the next accepted arm.
interface keypad_entry_buffer_if;
    logic        arm;
    logic [3:0]  input_style;
    logic        key_valid;
    logic [7:0]  ascii;
    logic        busy;
    logic [3:0]  digit_count;
    logic [31:0] bcd_out;
    logic [26:0] value_out;
    logic        done;
    logic [3:0]  status_code;
    logic        entry_error;
    logic [1:0]  state_dbg;

    modport master (
        output arm, input_style, key_valid, ascii,
        input  busy, digit_count, bcd_out, value_out, done,
               status_code, entry_error, state_dbg
    );

    modport slave (
        input  arm, input_style, key_valid, ascii,
        output busy, digit_count, bcd_out, value_out, done,
               status_code, entry_error, state_dbg
    );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: collects decoded keystrokes into a packed-BCD entry
// (account number, PIN, amount or single-key choice), handles backspace,
// enter and escape, then converts the entry to binary MSD-first and reports
// completion or exit with a one-cycle done strobe.
module keypad_entry_buffer #(
    parameter int          ACC_LEN        = 6,
    parameter int          PIN_LEN        = 4,
    parameter int          AMT_MAX        = 7,
    parameter logic [3:0]  INPUT_COMPLETE = 4'b1000,
    parameter logic [3:0]  EXIT           = 4'b0111
) (
    input  logic             clk,
    input  logic             rst,
    keypad_entry_buffer_if.slave kif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] STYLE_SINGLE   = 4'd1;
    localparam logic [3:0] STYLE_ACC      = 4'd2;
    localparam logic [3:0] STYLE_PIN      = 4'd3;
    localparam logic [3:0] STYLE_MENU     = 4'd4;
    localparam logic [3:0] STYLE_CURRENCY = 4'd5;
    localparam logic [3:0] STYLE_AMOUNT   = 4'd6;

    localparam logic [3:0] ACC_LIMIT = 4'(ACC_LEN);
    localparam logic [3:0] PIN_LIMIT = 4'(PIN_LEN);
    localparam logic [3:0] AMT_LIMIT = 4'(AMT_MAX);

    localparam logic [7:0] KEY_BACKSPACE = 8'h08;
    localparam logic [7:0] KEY_ENTER     = 8'h0D;
    localparam logic [7:0] KEY_ESCAPE    = 8'h1B;

    state_t      state_q, state_d;
    logic [3:0]  style_q, style_d;
    logic [3:0]  limit_q, limit_d;
    logic [31:0] bcd_q, bcd_d;
    logic [3:0]  count_q, count_d;
    logic [26:0] value_q, value_d;
    logic [3:0]  status_q, status_d;
    logic [26:0] acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic        err_q, err_d;

    logic        key_digit;
    logic        key_bs;
    logic        key_enter;
    logic        key_esc;
    logic [3:0]  key_nibble;
    logic        cur_single;
    logic [2:0]  conv_sel;
    logic [3:0]  conv_nibble;

    function automatic logic style_supported(input logic [3:0] s);
        return (s >= STYLE_SINGLE) && (s <= STYLE_AMOUNT);
    endfunction

    function automatic logic style_single(input logic [3:0] s);
        return (s == STYLE_SINGLE) || (s == STYLE_MENU) || (s == STYLE_CURRENCY);
    endfunction

    function automatic logic [3:0] style_limit(input logic [3:0] s);
        case (s)
            STYLE_ACC:    return ACC_LIMIT;
            STYLE_PIN:    return PIN_LIMIT;
            STYLE_AMOUNT: return AMT_LIMIT;
            default:      return 4'd1;
        endcase
    endfunction

    // Classify the incoming key and pick the digit the converter consumes next.
    always_comb begin
        key_digit   = kif.key_valid && (kif.ascii >= 8'h30) && (kif.ascii <= 8'h39);
        key_bs      = kif.key_valid && (kif.ascii == KEY_BACKSPACE);
        key_enter   = kif.key_valid && (kif.ascii == KEY_ENTER);
        key_esc     = kif.key_valid && (kif.ascii == KEY_ESCAPE);
        key_nibble  = kif.ascii[3:0];
        cur_single  = style_single(style_q);
        // Most significant held digit first: nibble index count-1-idx.
        conv_sel    = 3'(count_q - 4'd1 - idx_q);
        conv_nibble = bcd_q[{conv_sel, 2'b00} +: 4];
    end

    // Next-state and datapath update; arm overrides everything else.
    always_comb begin
        state_d  = state_q;
        style_d  = style_q;
        limit_d  = limit_q;
        bcd_d    = bcd_q;
        count_d  = count_q;
        value_d  = value_q;
        status_d = status_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        err_d    = 1'b0;

        if (kif.arm) begin
            if (style_supported(kif.input_style)) begin
                state_d  = COLLECT;
                style_d  = kif.input_style;
                limit_d  = style_limit(kif.input_style);
                bcd_d    = 32'h0;
                count_d  = 4'd0;
                value_d  = 27'd0;
                status_d = 4'b0000;
            end else begin
                // Unknown style: refuse the entry and fall back to idle.
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end

                COLLECT: begin
                    if (key_esc) begin
                        state_d  = DONE;
                        status_d = EXIT;
                        value_d  = 27'd0;
                    end else if (key_digit) begin
                        if (cur_single) begin
                            bcd_d   = {28'h0, key_nibble};
                            count_d = 4'd1;
                            acc_d   = 27'd0;
                            idx_d   = 4'd0;
                            state_d = CONVERT;
                        end else if (count_q < limit_q) begin
                            bcd_d   = {bcd_q[27:0], key_nibble};
                            count_d = count_q + 4'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_bs && !cur_single) begin
                        if (count_q != 4'd0) begin
                            bcd_d   = {4'h0, bcd_q[31:4]};
                            count_d = count_q - 4'd1;
                        end
                    end else if (key_enter && !cur_single) begin
                        // Amounts accept any non-empty entry; account and PIN
                        // entries must be exactly full.
                        if ((style_q == STYLE_AMOUNT) ? (count_q != 4'd0)
                                                      : (count_q == limit_q)) begin
                            acc_d   = 27'd0;
                            idx_d   = 4'd0;
                            state_d = CONVERT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                CONVERT: begin
                    if (idx_q == count_q) begin
                        value_d  = acc_q;
                        status_d = INPUT_COMPLETE;
                        state_d  = DONE;
                    end else begin
                        acc_d = 27'(acc_q * 27'd10) + {23'h0, conv_nibble};
                        idx_d = idx_q + 4'd1;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry, conversion and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            style_q  <= 4'd0;
            limit_q  <= 4'd0;
            bcd_q    <= 32'h0;
            count_q  <= 4'd0;
            value_q  <= 27'd0;
            status_q <= 4'b0000;
            acc_q    <= 27'd0;
            idx_q    <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            style_q  <= style_d;
            limit_q  <= limit_d;
            bcd_q    <= bcd_d;
            count_q  <= count_d;
            value_q  <= value_d;
            status_q <= status_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign kif.busy        = (state_q == COLLECT) || (state_q == CONVERT);
    assign kif.done        = (state_q == DONE);
    assign kif.digit_count = count_q;
    assign kif.bcd_out     = bcd_q;
    assign kif.value_out   = value_q;
    assign kif.status_code = status_q;
    assign kif.entry_error = err_q;
    assign kif.state_dbg   = state_q;

endmodule
